// File: rtl/dht11_scheduler_if.sv
// dht11_scheduler_if
//   Bundles every non-clock signal of the DHT11 measurement scheduler.
//   Suffixes are from the scheduler's point of view: *_i are driven into
//   the scheduler, *_o are produced by it.
//
//   Handshake semantics (single comment for the whole bus):
//     tick_i, force_i, dht_start_o and dht_done_i are one-clk strobes,
//     sampled on the rising clk edge. There is no ready/back-pressure:
//     a strobe that arrives while the scheduler is not in a state that
//     consumes it is dropped, never queued. dht_chk_err_i, dht_hum_i and
//     dht_temp_i are only meaningful in the same clk as dht_done_i.
//     All *_o signals are registered.
//
//   Modports:
//     slave  - the scheduler itself
//     master - whatever drives the scheduler (controller glue / bench)
interface dht11_scheduler_if;
  logic       tick_i;         // 1 us strobe
  logic       enable_i;       // level: periodic measuring enabled
  logic       force_i;        // request an immediate measurement
  logic       dht_start_o;    // start pulse to the 1-wire controller
  logic       dht_done_i;     // end-of-frame pulse from the controller
  logic       dht_chk_err_i;  // checksum error, qualified by dht_done_i
  logic [7:0] dht_hum_i;      // humidity from the controller
  logic [7:0] dht_temp_i;     // temperature from the controller
  logic [7:0] humidity_o;     // last good humidity
  logic [7:0] temperature_o;  // last good temperature
  logic       valid_o;        // a good reading has been latched
  logic       fail_o;         // retries exhausted
  logic [1:0] retry_cnt_o;    // retries used in the current cycle
  logic [7:0] meas_count_o;   // good readings, wraps
  logic [2:0] state_out_o;    // FSM state for LEDs / debug

  modport slave (
    input  tick_i, enable_i, force_i, dht_done_i, dht_chk_err_i,
           dht_hum_i, dht_temp_i,
    output dht_start_o, humidity_o, temperature_o, valid_o, fail_o,
           retry_cnt_o, meas_count_o, state_out_o
  );

  modport master (
    output tick_i, enable_i, force_i, dht_done_i, dht_chk_err_i,
           dht_hum_i, dht_temp_i,
    input  dht_start_o, humidity_o, temperature_o, valid_o, fail_o,
           retry_cnt_o, meas_count_o, state_out_o
  );
endinterface

// File: rtl/dht11_scheduler.sv
// dht11_scheduler
//   Measurement sequencer in front of the DHT11 1-wire controller.
//   Periodically pulses dht_start_o, waits for dht_done_i or a timeout,
//   retries failed attempts up to MAX_RETRY times and latches only
//   checksum-good readings onto humidity_o / temperature_o.
//
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     bus   - dht11_scheduler_if.slave (strobes, controller link,
//             latched results, status and state debug output)
//
//   Parameters (all in 1 us ticks except MAX_RETRY):
//     PERIOD_US    - idle gap from CHECK exit to the next TRIGGER
//     TIMEOUT_US   - ticks allowed in MEASURE before the attempt fails
//     RETRY_GAP_US - ticks between a failed attempt and its retry
//     MAX_RETRY    - retries after the first failed attempt (0..3)
module dht11_scheduler #(
  parameter int unsigned PERIOD_US    = 2000000,
  parameter int unsigned TIMEOUT_US   = 50000,
  parameter int unsigned RETRY_GAP_US = 1000000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             reset,
  dht11_scheduler_if.slave bus
);

  localparam int unsigned MAX_AB = (PERIOD_US > TIMEOUT_US) ? PERIOD_US : TIMEOUT_US;
  localparam int unsigned MAX_US = (MAX_AB > RETRY_GAP_US) ? MAX_AB : RETRY_GAP_US;
  localparam int          CW     = (MAX_US > 1) ? $clog2(MAX_US) : 1;

  localparam logic [CW-1:0] PERIOD_LAST  = CW'(PERIOD_US - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(RETRY_GAP_US - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_TRIGGER     = 3'd1,
    S_MEASURE     = 3'd2,
    S_CHECK       = 3'd3,
    S_RETRY_WAIT  = 3'd4,
    S_WAIT_PERIOD = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    hold_hum_q;
  logic [7:0]    hold_temp_q;
  logic          hold_err_q;
  logic          timeout_q;
  logic          start_q;
  logic [7:0]    hum_q;
  logic [7:0]    temp_q;
  logic          valid_q;
  logic          fail_q;
  logic [1:0]    retry_q;
  logic [7:0]    meas_q;

  // A timed-out attempt is bad even if a stale checksum flag says otherwise.
  logic attempt_good;
  assign attempt_good = !timeout_q && !hold_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_hum_q  <= '0;
      hold_temp_q <= '0;
      hold_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      hum_q       <= '0;
      temp_q      <= '0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
      meas_q      <= '0;
    end else begin
      // dht_start_o is registered, so it is raised on the edge that enters
      // TRIGGER and therefore is high exactly while the FSM sits in TRIGGER.
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.enable_i) begin
            state_q <= S_TRIGGER;
            start_q <= 1'b1;
          end
        end

        // The controller cannot be aborted, so enable_i is only honoured
        // again once the attempt reaches CHECK.
        S_TRIGGER: begin
          cnt_q     <= '0;
          timeout_q <= 1'b0;
          state_q   <= S_MEASURE;
        end

        S_MEASURE: begin
          if (bus.dht_done_i) begin
            // done has priority over a coincident timeout tick
            hold_hum_q  <= bus.dht_hum_i;
            hold_temp_q <= bus.dht_temp_i;
            hold_err_q  <= bus.dht_chk_err_i;
            timeout_q   <= 1'b0;
            state_q     <= S_CHECK;
          end else if (bus.tick_i) begin
            if (cnt_q == TIMEOUT_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= S_CHECK;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_CHECK: begin
          cnt_q <= '0;
          if (attempt_good) begin
            hum_q   <= hold_hum_q;
            temp_q  <= hold_temp_q;
            valid_q <= 1'b1;
            fail_q  <= 1'b0;
            retry_q <= '0;
            meas_q  <= meas_q + 8'd1;
            state_q <= S_WAIT_PERIOD;
          end else if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + 2'd1;
            state_q <= S_RETRY_WAIT;
          end else begin
            fail_q  <= 1'b1;
            retry_q <= '0;
            state_q <= S_WAIT_PERIOD;
          end
          // Outputs above still update; only the destination changes.
          if (!bus.enable_i) state_q <= S_IDLE;
        end

        S_RETRY_WAIT: begin
          if (!bus.enable_i) begin
            state_q <= S_IDLE;
          end else if (bus.tick_i) begin
            if (cnt_q == GAP_LAST) begin
              state_q <= S_TRIGGER;
              start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_WAIT_PERIOD: begin
          if (!bus.enable_i) begin
            state_q <= S_IDLE;
          end else if (bus.force_i) begin
            state_q <= S_TRIGGER;
            start_q <= 1'b1;
          end else if (bus.tick_i) begin
            if (cnt_q == PERIOD_LAST) begin
              state_q <= S_TRIGGER;
              start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.dht_start_o   = start_q;
  assign bus.humidity_o    = hum_q;
  assign bus.temperature_o = temp_q;
  assign bus.valid_o       = valid_q;
  assign bus.fail_o        = fail_q;
  assign bus.retry_cnt_o   = retry_q;
  assign bus.meas_count_o  = meas_q;
  assign bus.state_out_o   = state_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb_dht11_scheduler
//   Self-checking bench for dht11_scheduler with short timing parameters
//   (PERIOD 100, TIMEOUT 20, RETRY_GAP 10, MAX_RETRY 2, tick every 10 clk).
//   All inputs, including tick, are driven from the single main thread on
//   the falling clk edge; outputs are sampled on that same falling edge
//   before new inputs are applied. Good readings are pushed to exp_q when
//   dht_done is driven and popped whenever meas_count moves.
module tb_dht11_scheduler;

  localparam int PERIOD_US    = 100;
  localparam int TIMEOUT_US   = 20;
  localparam int RETRY_GAP_US = 10;
  localparam int MAX_RETRY    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dht11_scheduler_if bus ();

  dht11_scheduler #(
    .PERIOD_US    (PERIOD_US),
    .TIMEOUT_US   (TIMEOUT_US),
    .RETRY_GAP_US (RETRY_GAP_US),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- bench state ----------------
  int          tests;
  int          fails;
  logic [15:0] exp_q[$];
  int          ticks_seen;
  int          start_cnt;
  int          tick_div;
  logic        prev_start;
  logic [7:0]  prev_meas;
  logic [7:0]  model_meas;

  // ---------------- monitor / scoreboard ----------------
  task automatic sample();
    logic [15:0] e;
    logic [7:0]  next_meas;
    if (bus.tick_i) ticks_seen++;
    if (bus.dht_start_o) begin
      start_cnt++;
      tests++;
      if (prev_start) begin
        fails++;
        $display("FAIL start_width: dht_start high 2+ clk, required 1 clk");
      end
    end
    prev_start = bus.dht_start_o;
    if (bus.meas_count_o !== prev_meas) begin
      tests++;
      next_meas = prev_meas + 8'd1;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: meas_count %0d -> %0d with no good reading pending",
                 prev_meas, bus.meas_count_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.humidity_o, bus.temperature_o} !== e || bus.meas_count_o !== next_meas) begin
          fails++;
          $display("FAIL sb_reading: got hum=%h temp=%h cnt=%0d, required hum=%h temp=%h cnt=%0d",
                   bus.humidity_o, bus.temperature_o, bus.meas_count_o,
                   e[15:8], e[7:0], next_meas);
        end
      end
      prev_meas = bus.meas_count_o;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    sample();
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    bus.tick_i = (tick_div == 9);
  endtask

  task automatic wait_start(input int budget);
    int s0;
    int n;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < budget) begin
      cycle();
      n++;
    end
    tests++;
    if (start_cnt == s0) begin
      fails++;
      $display("FAIL start_timeout: no dht_start within %0d clk", budget);
    end
  endtask

  // Called with the DUT in MEASURE; leaves it one clk after CHECK.
  task automatic respond(input logic [7:0] hum, input logic [7:0] temp, input logic err);
    bus.dht_done_i    = 1'b1;
    bus.dht_hum_i     = hum;
    bus.dht_temp_i    = temp;
    bus.dht_chk_err_i = err;
    if (!err) begin
      exp_q.push_back({hum, temp});
      model_meas = model_meas + 8'd1;
    end
    cycle();
    bus.dht_done_i    = 1'b0;
    bus.dht_chk_err_i = 1'b0;
    bus.dht_hum_i     = 8'($urandom_range(0, 255));
    bus.dht_temp_i    = 8'($urandom_range(0, 255));
    cycle();
  endtask

  // From WAIT_PERIOD: force a new attempt and leave the DUT in MEASURE.
  task automatic kick();
    int s0;
    s0 = start_cnt;
    bus.force_i = 1'b1;
    cycle();
    bus.force_i = 1'b0;
    tests++;
    if (start_cnt != s0 + 1) begin
      fails++;
      $display("FAIL kick_start: starts seen %0d, required %0d", start_cnt - s0, 1);
    end
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int s0;
    reset             = 1'b1;
    bus.tick_i        = 1'b0;
    bus.enable_i      = 1'b0;
    bus.force_i       = 1'b0;
    bus.dht_done_i    = 1'b0;
    bus.dht_chk_err_i = 1'b0;
    bus.dht_hum_i     = 8'h00;
    bus.dht_temp_i    = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.dht_start_o, bus.humidity_o, bus.temperature_o, bus.valid_o, bus.fail_o,
         bus.retry_cnt_o, bus.meas_count_o, bus.state_out_o} !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: start=%b hum=%h temp=%h valid=%b fail=%b retry=%0d cnt=%0d st=%0d, required all 0",
               bus.dht_start_o, bus.humidity_o, bus.temperature_o, bus.valid_o, bus.fail_o,
               bus.retry_cnt_o, bus.meas_count_o, bus.state_out_o);
    end
    reset = 1'b0;
    s0 = start_cnt;
    repeat (5) cycle();
    bus.force_i = 1'b1;  // ignored while disabled
    cycle();
    bus.force_i = 1'b0;
    repeat (30) cycle();
    tests++;
    if (bus.state_out_o !== 3'd0 || start_cnt != s0) begin
      fails++;
      $display("FAIL idle_disabled: state=%0d starts=%0d, required state=0 starts=0",
               bus.state_out_o, start_cnt - s0);
    end
  endtask

  task automatic test_normal();
    int t0;
    bus.enable_i = 1'b1;
    cycle();
    tests++;
    if (bus.dht_start_o !== 1'b1 || bus.state_out_o !== 3'd1) begin
      fails++;
      $display("FAIL first_start: start=%b state=%0d, required start=1 state=1",
               bus.dht_start_o, bus.state_out_o);
    end
    cycle();
    respond(8'h37, 8'h19, 1'b0);
    tests++;
    if (bus.humidity_o !== 8'h37 || bus.temperature_o !== 8'h19 || bus.valid_o !== 1'b1 ||
        bus.meas_count_o !== 8'd1 || bus.state_out_o !== 3'd5) begin
      fails++;
      $display("FAIL normal_latch: hum=%h temp=%h valid=%b cnt=%0d st=%0d, required 37 19 1 1 5",
               bus.humidity_o, bus.temperature_o, bus.valid_o, bus.meas_count_o, bus.state_out_o);
    end
    t0 = ticks_seen;
    wait_start(1300);
    tests++;
    if (ticks_seen - t0 != PERIOD_US) begin
      fails++;
      $display("FAIL period_ticks: %0d ticks, required %0d", ticks_seen - t0, PERIOD_US);
    end
    cycle();  // now in MEASURE
  endtask

  task automatic test_retry_exhaust();
    int t0;
    for (int a = 1; a <= MAX_RETRY; a++) begin
      respond(8'h11, 8'h22, 1'b1);
      tests++;
      if (bus.retry_cnt_o !== 2'(a) || bus.fail_o !== 1'b0 || bus.humidity_o !== 8'h37 ||
          bus.state_out_o !== 3'd4) begin
        fails++;
        $display("FAIL retry_step: retry=%0d fail=%b hum=%h st=%0d, required retry=%0d fail=0 hum=37 st=4",
                 bus.retry_cnt_o, bus.fail_o, bus.humidity_o, bus.state_out_o, a);
      end
      t0 = ticks_seen;
      wait_start(200);
      tests++;
      if (ticks_seen - t0 != RETRY_GAP_US) begin
        fails++;
        $display("FAIL retry_gap: %0d ticks, required %0d", ticks_seen - t0, RETRY_GAP_US);
      end
      cycle();
    end
    respond(8'h11, 8'h22, 1'b1);
    tests++;
    if (bus.fail_o !== 1'b1 || bus.retry_cnt_o !== 2'd0 || bus.humidity_o !== 8'h37 ||
        bus.temperature_o !== 8'h19 || bus.valid_o !== 1'b1 || bus.state_out_o !== 3'd5) begin
      fails++;
      $display("FAIL retry_exhaust: fail=%b retry=%0d hum=%h temp=%h valid=%b st=%0d, required 1 0 37 19 1 5",
               bus.fail_o, bus.retry_cnt_o, bus.humidity_o, bus.temperature_o, bus.valid_o, bus.state_out_o);
    end
    kick();
    respond(8'h40, 8'h1a, 1'b0);
    tests++;
    if (bus.fail_o !== 1'b0 || bus.humidity_o !== 8'h40 || bus.meas_count_o !== 8'd2) begin
      fails++;
      $display("FAIL fail_clear: fail=%b hum=%h cnt=%0d, required 0 40 2",
               bus.fail_o, bus.humidity_o, bus.meas_count_o);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int n;
    kick();
    t0 = ticks_seen;
    n = 0;
    while (bus.state_out_o !== 3'd3 && n < 400) begin
      cycle();
      n++;
    end
    tests++;
    if (bus.state_out_o !== 3'd3 || ticks_seen - t0 != TIMEOUT_US) begin
      fails++;
      $display("FAIL timeout_ticks: state=%0d after %0d ticks, required state=3 after %0d",
               bus.state_out_o, ticks_seen - t0, TIMEOUT_US);
    end
    cycle();
    tests++;
    if (bus.retry_cnt_o !== 2'd1 || bus.state_out_o !== 3'd4 || bus.humidity_o !== 8'h40) begin
      fails++;
      $display("FAIL timeout_retry: retry=%0d st=%0d hum=%h, required 1 4 40",
               bus.retry_cnt_o, bus.state_out_o, bus.humidity_o);
    end
    t0 = ticks_seen;
    wait_start(200);
    tests++;
    if (ticks_seen - t0 != RETRY_GAP_US) begin
      fails++;
      $display("FAIL timeout_gap: %0d ticks, required %0d", ticks_seen - t0, RETRY_GAP_US);
    end
    cycle();
    respond(8'h41, 8'h1b, 1'b0);
    tests++;
    if (bus.retry_cnt_o !== 2'd0 || bus.humidity_o !== 8'h41) begin
      fails++;
      $display("FAIL timeout_recover: retry=%0d hum=%h, required 0 41", bus.retry_cnt_o, bus.humidity_o);
    end
  endtask

  task automatic test_force();
    int t0;
    int n;
    int s0;
    t0 = ticks_seen;
    n = 0;
    while (ticks_seen - t0 < 5 && n < 200) begin
      cycle();
      n++;
    end
    bus.force_i = 1'b1;
    cycle();
    bus.force_i = 1'b0;
    tests++;
    if (bus.dht_start_o !== 1'b1 || bus.state_out_o !== 3'd1) begin
      fails++;
      $display("FAIL force_start: start=%b st=%0d, required start=1 st=1",
               bus.dht_start_o, bus.state_out_o);
    end
    cycle();
    s0 = start_cnt;
    bus.force_i = 1'b1;  // during MEASURE: must be dropped
    cycle();
    bus.force_i = 1'b0;
    repeat (5) cycle();
    tests++;
    if (start_cnt != s0 || bus.state_out_o !== 3'd2) begin
      fails++;
      $display("FAIL force_in_measure: extra starts=%0d st=%0d, required 0 2",
               start_cnt - s0, bus.state_out_o);
    end
    respond(8'h42, 8'h1c, 1'b0);
  endtask

  task automatic test_coincident();
    int t0;
    int n;
    kick();
    t0 = ticks_seen;
    n = 0;
    while (!(ticks_seen - t0 == TIMEOUT_US - 1 && bus.tick_i) && n < 400) begin
      cycle();
      n++;
    end
    respond(8'h43, 8'h1d, 1'b0);
    tests++;
    if (bus.humidity_o !== 8'h43 || bus.fail_o !== 1'b0 || bus.retry_cnt_o !== 2'd0 ||
        bus.state_out_o !== 3'd5) begin
      fails++;
      $display("FAIL done_vs_timeout: hum=%h fail=%b retry=%0d st=%0d, required 43 0 0 5",
               bus.humidity_o, bus.fail_o, bus.retry_cnt_o, bus.state_out_o);
    end
  endtask

  task automatic test_enable_drop();
    int s0;
    kick();
    bus.enable_i = 1'b0;
    respond(8'h44, 8'h1e, 1'b0);
    tests++;
    if (bus.humidity_o !== 8'h44 || bus.state_out_o !== 3'd0) begin
      fails++;
      $display("FAIL drop_in_measure: hum=%h st=%0d, required 44 0", bus.humidity_o, bus.state_out_o);
    end
    s0 = start_cnt;
    repeat (150) cycle();
    bus.force_i = 1'b1;
    cycle();
    bus.force_i = 1'b0;
    repeat (150) cycle();
    tests++;
    if (start_cnt != s0 || bus.state_out_o !== 3'd0) begin
      fails++;
      $display("FAIL idle_stays: starts=%0d st=%0d, required 0 0", start_cnt - s0, bus.state_out_o);
    end
    bus.enable_i = 1'b1;
    cycle();
    cycle();
    respond(8'h45, 8'h1f, 1'b0);
    repeat (3) cycle();
    bus.enable_i = 1'b0;
    cycle();
    tests++;
    if (bus.state_out_o !== 3'd0) begin
      fails++;
      $display("FAIL drop_in_wait: st=%0d, required 0", bus.state_out_o);
    end
    bus.enable_i = 1'b1;
    cycle();
    cycle();
    respond(8'h46, 8'h20, 1'b0);
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    while (model_meas != 8'd0 && n < 300) begin
      kick();
      respond(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      n++;
    end
    tests++;
    if (bus.meas_count_o !== 8'd0 || bus.valid_o !== 1'b1) begin
      fails++;
      $display("FAIL count_wrap: cnt=%0d valid=%b, required 0 1", bus.meas_count_o, bus.valid_o);
    end
  endtask

  task automatic test_async_reset();
    kick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({bus.dht_start_o, bus.humidity_o, bus.temperature_o, bus.valid_o, bus.fail_o,
         bus.retry_cnt_o, bus.meas_count_o, bus.state_out_o} !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: hum=%h temp=%h valid=%b fail=%b cnt=%0d st=%0d, required all 0",
               bus.humidity_o, bus.temperature_o, bus.valid_o, bus.fail_o,
               bus.meas_count_o, bus.state_out_o);
    end
    exp_q.delete();
    model_meas = 8'd0;
    prev_meas  = 8'd0;
    prev_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();
    tests++;
    if (bus.dht_start_o !== 1'b1) begin
      fails++;
      $display("FAIL restart_after_reset: start=%b, required 1", bus.dht_start_o);
    end
    cycle();
    respond(8'h50, 8'h21, 1'b0);
    tests++;
    if (bus.meas_count_o !== 8'd1 || bus.humidity_o !== 8'h50) begin
      fails++;
      $display("FAIL post_reset_read: cnt=%0d hum=%h, required 1 50", bus.meas_count_o, bus.humidity_o);
    end
    bus.enable_i = 1'b0;
    repeat (3) cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests      = 0;
    fails      = 0;
    ticks_seen = 0;
    start_cnt  = 0;
    tick_div   = 0;
    prev_start = 1'b0;
    prev_meas  = 8'd0;
    model_meas = 8'd0;

    test_reset();
    test_normal();
    test_retry_exhaust();
    test_timeout();
    test_force();
    test_coincident();
    test_enable_drop();
    test_wrap();
    test_async_reset();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d readings never appeared, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a loop bound is ever defeated.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dht11_scheduler.md
Name: dht11_scheduler

Overview:
Measurement sequencer sitting in front of the DHT11 1-wire controller. It periodically issues a start pulse to the controller and waits for the end-of-frame pulse or a timeout. On checksum error or timeout it retries up to MAX_RETRY times. Only checksum-good readings are latched into the humidity/temperature outputs feeding the FND/UART display path.

Parameters:
PERIOD_US, 2000000, idle gap in 1 us ticks between measurement cycles (sensor minimum is 1 s)
TIMEOUT_US, 50000, max ticks in MEASURE before the attempt is declared failed
RETRY_GAP_US, 1000000, ticks waited before re-triggering after a failed attempt
MAX_RETRY, 3, retries after the first failed attempt (range 0..3)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
tick  input  1  1 us strobe, one clk wide
enable  input  1  level; 1 = periodic measuring runs
force  input  1  one-clk request to measure now
dht_start  output  1  one-clk start pulse to the controller
dht_done  input  1  one-clk end-of-frame pulse from the controller
dht_chk_err  input  1  checksum error, valid only while dht_done=1
dht_hum  input  8  controller humidity, valid with dht_done
dht_temp  input  8  controller temperature, valid with dht_done
humidity  output  8  last good humidity
temperature  output  8  last good temperature
valid  output  1  1 once any good reading has been latched
fail  output  1  1 after retries are exhausted; cleared by the next good reading
retry_cnt  output  2  number of retries used in the current cycle
meas_count  output  8  count of good readings, wraps 255->0
state_out  output  3  current state encoding, for LEDs

Behaviour:
- Reset (asynchronous, clears immediately):
  - state = IDLE.
  - All outputs = 0, including dht_start, valid, fail, retry_cnt and meas_count.
  - Internal tick counter = 0.
- State encodings: IDLE=0, TRIGGER=1, MEASURE=2, CHECK=3, RETRY_WAIT=4, WAIT_PERIOD=5.
- IDLE: if enable=1, go to TRIGGER on the next clk, so the first measurement starts without the period wait. force is ignored while enable=0.
- TRIGGER: dht_start=1 for exactly this one clk; clear tick counter; go to MEASURE. dht_start is 0 in every other state.
- MEASURE:
  - On dht_done=1: latch dht_hum, dht_temp and dht_chk_err into holding registers; go to CHECK.
  - On tick=1 with counter == TIMEOUT_US-1 (and no dht_done): set a timeout flag; go to CHECK.
  - On any other tick: counter+1.
  - If dht_done and the timeout tick coincide, dht_done wins.
- CHECK (exactly 1 clk):
  - Good (done without chk_err, no timeout):
    - humidity/temperature <= held values; valid=1; fail=0.
    - retry_cnt=0; meas_count+1.
    - Next state is WAIT_PERIOD.
  - Bad, retry_cnt < MAX_RETRY: retry_cnt+1; go to RETRY_WAIT.
  - Bad, retry_cnt == MAX_RETRY: fail=1; retry_cnt=0; go to WAIT_PERIOD. humidity, temperature and valid hold their previous values.
  - Override: if enable=0 in CHECK, the next state is IDLE. Outputs still update as above.
  - The tick counter is cleared on exit from CHECK.
- RETRY_WAIT: count ticks to RETRY_GAP_US-1, then go to TRIGGER.
- WAIT_PERIOD:
  - Count ticks to PERIOD_US-1, then go to TRIGGER.
  - force=1 goes to TRIGGER on the next clk and preempts the counter.
- Period semantics: the period is measured from CHECK exit to the next TRIGGER, not start-to-start.
- enable=0:
  - In WAIT_PERIOD or RETRY_WAIT: go to IDLE on the next clk.
  - In TRIGGER or MEASURE: the attempt completes (the controller cannot be aborted), then CHECK goes to IDLE.
- Ignored inputs:
  - force outside WAIT_PERIOD and IDLE-with-enable has no effect; it is not queued.
  - dht_done outside MEASURE is ignored.
- Counter width: clog2 of the largest of PERIOD_US, TIMEOUT_US and RETRY_GAP_US.
- Latency: dht_done to humidity update is 2 clk (MEASURE->CHECK, CHECK->registered output).

Test Plan:
Bench parameters: PERIOD_US=100, TIMEOUT_US=20, RETRY_GAP_US=10, MAX_RETRY=2; tick every 10 clk.
1. Normal cycle: enable=1 after reset -> dht_start pulse 1 clk later. Respond with dht_done, hum=0x37, temp=0x19, chk_err=0 -> 2 clk later humidity=0x37, temperature=0x19, valid=1, meas_count=1. Next dht_start after 100 ticks.
2. Retry exhaustion: answer 3 consecutive attempts with chk_err=1 -> retry_cnt steps 1, 2, then fail=1 and retry_cnt=0. Humidity holds its prior value; 10-tick gap between attempts. A following good reading clears fail.
3. Timeout: never pulse dht_done -> CHECK entered on the 20th tick after the start pulse. Treated as bad: retry_cnt=1, then dht_start again after 10 ticks.
4. Force: pulse force 5 ticks into WAIT_PERIOD -> dht_start 1 clk later (TRIGGER then MEASURE). force pulsed during MEASURE -> no extra start pulse.
5. enable drop: drop enable in MEASURE -> the attempt completes, CHECK updates outputs, then IDLE with no further dht_start. Drop in WAIT_PERIOD -> IDLE next clk.
6. Edge cases:
   - dht_done coincident with the timeout tick -> treated as done (good).
   - 256 good readings -> meas_count wraps to 0.
   - Async reset asserted mid-MEASURE -> all outputs 0 immediately, IDLE.
